receiver_stream_arbiter: RTL and testbench

RECEIVER_STREAM_ARBITER -- requirements
Module: receiver_stream_arbiter

---
 rtl/receiver_pkg.sv | 28 ++
 rtl/packet_fifo.sv | 57 +++++
 rtl/receiver_stream_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_receiver_stream_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared types for the receiver stream arbiter slice.
//   tPacket    : one stream word {SoP, EoP, Data[13:0], Valid}
//   tFifoEntry : one per-channel FIFO entry {SoP, EoP, Abort, Data}
//   tArbState  : arbiter states
//   MAX_CH     : largest supported number of merged streams
package receiver_pkg;
  localparam int MAX_CH = 4;
  localparam int DATA_W = 14;

  typedef struct packed {
    logic              SoP;
    logic              EoP;
    logic [DATA_W-1:0] Data;
    logic              Valid;
  } tPacket;

  typedef struct packed {
    logic              SoP;
    logic              EoP;
    logic              Abort;
    logic [DATA_W-1:0] Data;
  } tFifoEntry;

  typedef enum logic {Idle, Forward} tArbState;

  // Terminates a packet truncated by overflow.
  localparam tFifoEntry ABORT_MARKER = '{SoP: 1'b0, EoP: 1'b1, Abort: 1'b1, Data: '0};
endpackage

// File: rtl/packet_fifo.sv
// Per-channel entry FIFO.
//   ipDspClk, Reset : clock, synchronous active-high flush
//   ipWrite/ipWrEntry : push one entry (ignored when completely full)
//   ipPop           : pop head (ignored when empty)
//   opHead/opNext   : head entry and the entry behind it (valid when count >= 2)
//   opCount         : occupancy; opEmpty; opFullM1 = count >= DEPTH-1
module packet_fifo
  import receiver_pkg::*;
#(
  parameter int DEPTH = 64
)(
  input  logic                     ipDspClk,
  input  logic                     Reset,
  input  logic                     ipWrite,
  input  tFifoEntry                ipWrEntry,
  input  logic                     ipPop,
  output tFifoEntry                opHead,
  output tFifoEntry                opNext,
  output logic [$clog2(DEPTH):0]   opCount,
  output logic                     opEmpty,
  output logic                     opFullM1
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tFifoEntry       mem [DEPTH];
  logic [AW-1:0]   wrPtr, rdPtr;
  logic            doWrite, doPop;

  assign opEmpty  = (opCount == '0);
  assign opFullM1 = (opCount >= CW'(DEPTH - 1));
  assign doWrite  = ipWrite && (opCount != CW'(DEPTH));
  assign doPop    = ipPop && !opEmpty;
  assign opHead   = mem[rdPtr];
  // Lookahead lets the output stage reload on the same cycle the head pops.
  assign opNext   = mem[rdPtr + 1'b1];

  always_ff @(posedge ipDspClk) begin
    if (Reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      opCount <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doPop)   rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doPop})
        2'b10:   opCount <= opCount + 1'b1;
        2'b01:   opCount <= opCount - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ipDspClk) begin
    if (doWrite) mem[wrPtr] <= ipWrEntry;
  end
endmodule

// File: rtl/receiver_stream_arbiter.sv
// Merges NUM_CH receiver packet streams (no backpressure) into one stream
// with ready/valid flow control. Each channel is buffered in a packet_fifo;
// overflow truncates the packet with an abort marker and drops samples until
// the next SoP. Grants are round-robin and never switch mid-packet.
//   ipDspClk, Reset : clock, synchronous active-high reset
//   ipPacket        : per-channel input words
//   opPacket, opChannel, opAbort : registered merged output
//   ipReady         : downstream accepts opPacket this cycle
//   opOverflow      : sticky per-channel overflow flags
// Optional (macro ARBITER_STATS_EN): opPacketCount / opAbortCount,
//   saturating per-channel counts of completed and aborted packets.
module receiver_stream_arbiter
  import receiver_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 64
)(
  input  logic                     ipDspClk,
  input  logic                     Reset,
  input  tPacket [NUM_CH-1:0]      ipPacket,
  output tPacket                   opPacket,
  input  logic                     ipReady,
  output logic [1:0]               opChannel,
  output logic                     opAbort,
  output logic [NUM_CH-1:0]        opOverflow
`ifdef ARBITER_STATS_EN
  ,
  output logic [NUM_CH-1:0][15:0]  opPacketCount,
  output logic [NUM_CH-1:0][15:0]  opAbortCount
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tFifoEntry [NUM_CH-1:0]          wrEntry, head, nextHead;
  logic      [NUM_CH-1:0]          wrEn, pop, fifoEmpty, fifoFullM1, sopReady;
  logic      [NUM_CH-1:0][CW-1:0]  fifoCount;

  // ---------------- per-channel write / drop control ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    tPacket    smp;
    tFifoEntry ent;
    logic      wr, dropQ, dropNxt, ovfQ, ovfNxt;

    assign smp = ipPacket[c];

    always_comb begin
      wr      = 1'b0;
      ent     = '{SoP: smp.SoP, EoP: smp.EoP, Abort: 1'b0, Data: smp.Data};
      dropNxt = dropQ;
      ovfNxt  = ovfQ;
      if (smp.Valid) begin
        if (!fifoFullM1[c]) begin
          // While dropping, only a fresh SoP with room restarts the stream.
          if (!dropQ || smp.SoP) begin
            wr      = 1'b1;
            dropNxt = 1'b0;
          end
        end else if (!dropQ) begin
          // First lost sample: close the partial packet in the reserved slot.
          // A lost SoP has no partial packet behind it, so no marker then.
          ovfNxt  = 1'b1;
          dropNxt = 1'b1;
          if (!smp.SoP) begin
            wr  = 1'b1;
            ent = ABORT_MARKER;
          end
        end
      end
    end

    always_ff @(posedge ipDspClk) begin
      if (Reset) begin
        dropQ <= 1'b0;
        ovfQ  <= 1'b0;
      end else begin
        dropQ <= dropNxt;
        ovfQ  <= ovfNxt;
      end
    end

    assign wrEn[c]       = wr;
    assign wrEntry[c]    = ent;
    assign opOverflow[c] = ovfQ;
    assign sopReady[c]   = !fifoEmpty[c] && head[c].SoP;

    packet_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
      .ipDspClk  (ipDspClk),
      .Reset     (Reset),
      .ipWrite   (wrEn[c]),
      .ipWrEntry (wrEntry[c]),
      .ipPop     (pop[c]),
      .opHead    (head[c]),
      .opNext    (nextHead[c]),
      .opCount   (fifoCount[c]),
      .opEmpty   (fifoEmpty[c]),
      .opFullM1  (fifoFullM1[c])
    );
  end

  // ---------------- arbiter ----------------
  tArbState   state, nextState;
  logic [1:0] grantCh, nextGrant, rrPtr, nextRr, rrAfter, grantSel;
  logic       grantValid, xfer;
  tFifoEntry  gHead, gNext, src;
  logic [CW-1:0] gCount;
  tPacket     nextOut;
  logic [1:0] nextChan;
  logic       nextAbort;

  assign xfer    = opPacket.Valid && ipReady;
  assign rrAfter = (grantCh == 2'(NUM_CH - 1)) ? 2'd0 : grantCh + 2'd1;

  // Granted-channel view.
  always_comb begin
    gHead  = '0;
    gNext  = '0;
    gCount = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grantCh == 2'(c)) begin
        gHead  = head[c];
        gNext  = nextHead[c];
        gCount = fifoCount[c];
      end
    end
  end

  // Round-robin search from rrPtr; descending k so the closest candidate wins.
  always_comb begin
    grantValid = 1'b0;
    grantSel   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c == (int'(rrPtr) + k) % NUM_CH && sopReady[c]) begin
          grantValid = 1'b1;
          grantSel   = 2'(c);
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    nextGrant = grantCh;
    nextRr    = rrPtr;
    nextOut   = opPacket;
    nextChan  = opChannel;
    nextAbort = opAbort;
    pop       = '0;
    src       = gHead;
    case (state)
      Idle: begin
        nextOut.Valid = 1'b0;
        nextAbort     = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
          if (!fifoEmpty[c] && !head[c].SoP) pop[c] = 1'b1;
        if (grantValid) begin
          nextGrant = grantSel;
          nextState = Forward;
        end
      end
      Forward: begin
        // The output register mirrors the unpopped head; pop only on transfer.
        for (int c = 0; c < NUM_CH; c++)
          if (xfer && grantCh == 2'(c)) pop[c] = 1'b1;
        if (xfer && opPacket.EoP) begin
          nextState     = Idle;
          nextRr        = rrAfter;
          nextOut.Valid = 1'b0;
          nextAbort     = 1'b0;
        end else if (!opPacket.Valid || ipReady) begin
          src = xfer ? gNext : gHead;
          if (gCount >= (xfer ? CW'(2) : CW'(1))) begin
            nextOut.SoP   = src.SoP;
            nextOut.EoP   = src.EoP;
            nextOut.Data  = src.Data;
            nextOut.Valid = 1'b1;
            nextAbort     = src.Abort;
            nextChan      = grantCh;
          end else begin
            // Granted FIFO ran dry mid-packet: idle the output, keep the grant.
            nextOut.Valid = 1'b0;
            nextAbort     = 1'b0;
          end
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge ipDspClk) begin
    if (Reset) begin
      state     <= Idle;
      grantCh   <= '0;
      rrPtr     <= '0;
      opPacket  <= '0;
      opChannel <= '0;
      opAbort   <= 1'b0;
    end else begin
      state     <= nextState;
      grantCh   <= nextGrant;
      rrPtr     <= nextRr;
      opPacket  <= nextOut;
      opChannel <= nextChan;
      opAbort   <= nextAbort;
    end
  end

`ifdef ARBITER_STATS_EN
  always_ff @(posedge ipDspClk) begin
    if (Reset) begin
      opPacketCount <= '0;
      opAbortCount  <= '0;
    end else if (state == Forward && xfer && opPacket.EoP) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (grantCh == 2'(c)) begin
          if (opAbort) begin
            if (opAbortCount[c] != 16'hFFFF) opAbortCount[c] <= opAbortCount[c] + 16'd1;
          end else begin
            if (opPacketCount[c] != 16'hFFFF) opPacketCount[c] <= opPacketCount[c] + 16'd1;
          end
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_receiver_stream_arbiter.sv
module tb_receiver_stream_arbiter;
  import receiver_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;

  logic              ipDspClk = 1'b0;
  logic              Reset    = 1'b1;
  logic              ipReady  = 1'b0;
  tPacket [NCH-1:0]  ipPacket = '0;
  tPacket            opPacket;
  logic [1:0]        opChannel;
  logic              opAbort;
  logic [NCH-1:0]    opOverflow;
`ifdef ARBITER_STATS_EN
  logic [NCH-1:0][15:0] opPacketCount, opAbortCount;
`endif

  receiver_stream_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .ipDspClk   (ipDspClk),
    .Reset      (Reset),
    .ipPacket   (ipPacket),
    .opPacket   (opPacket),
    .ipReady    (ipReady),
    .opChannel  (opChannel),
    .opAbort    (opAbort),
    .opOverflow (opOverflow)
`ifdef ARBITER_STATS_EN
    ,
    .opPacketCount (opPacketCount),
    .opAbortCount  (opAbortCount)
`endif
  );

  always #5 ipDspClk = ~ipDspClk;

  int cyc = 0;
  always @(posedge ipDspClk) cyc <= cyc + 1;

  typedef struct {
    int         ch;
    logic       sop, eop, abort;
    logic [13:0] data;
    int         at;
  } word_t;
  word_t got[$];

  // Record every transfer the downstream accepts.
  always @(negedge ipDspClk)
    if (!Reset && opPacket.Valid && ipReady)
      got.push_back('{ch: int'(opChannel), sop: opPacket.SoP, eop: opPacket.EoP,
                      abort: opAbort, data: opPacket.Data, at: cyc});

  int checks = 0, failures = 0, t0 = 0;

  task automatic drive(input logic [1:0] mask, input int n, input logic [13:0] b0, input logic [13:0] b1);
    for (int i = 0; i < n; i++) begin
      @(posedge ipDspClk); #1;
      if (i == 0) t0 = cyc;
      for (int c = 0; c < NCH; c++) begin
        ipPacket[c].Valid = mask[c];
        ipPacket[c].SoP   = mask[c] && (i == 0);
        ipPacket[c].EoP   = mask[c] && (i == n - 1);
        ipPacket[c].Data  = mask[c] ? ((c == 0 ? b0 : b1) + 14'(i)) : 14'h0;
      end
    end
    @(posedge ipDspClk); #1;
    ipPacket = '0;
  endtask

  task automatic waitWords(input int n, input int budget);
    for (int k = 0; k < budget && got.size() < n; k++) @(posedge ipDspClk);
    repeat (4) @(posedge ipDspClk);
    @(negedge ipDspClk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge ipDspClk);
    @(negedge ipDspClk);
    checks++; if (opPacket.Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", opPacket.Valid); end
    checks++; if (opAbort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", opAbort); end
    checks++; if (opChannel !== 2'd0) begin failures++; $display("FAIL reset_channel got=%0d exp=0", opChannel); end
    checks++; if (opOverflow !== 2'b00) begin failures++; $display("FAIL reset_overflow got=%b exp=00", opOverflow); end
    @(posedge ipDspClk); #1; Reset = 1'b0;
  endtask

  task automatic test_single;
    got.delete(); ipReady = 1'b1;
    fork
      drive(2'b01, 10, 14'h100, 14'h0);
      waitWords(10, 100);
    join
    checks++; if (got.size() !== 10) begin failures++; $display("FAIL single_count got=%0d exp=10", got.size()); end
    checks++; if (got.size() == 0 || got[0].at !== t0 + 3) begin failures++;
      $display("FAIL single_latency got=%0d exp=%0d", got.size() == 0 ? -1 : got[0].at - t0, 3); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i].ch !== 0 || got[i].data !== 14'h100 + 14'(i) || got[i].sop !== (i == 0) ||
          got[i].eop !== (i == 9) || got[i].abort !== 1'b0) begin
        failures++;
        $display("FAIL single_word%0d got ch=%0d d=%h s=%b e=%b a=%b exp ch=0 d=%h s=%b e=%b a=0", i,
                 got[i].ch, got[i].data, got[i].sop, got[i].eop, got[i].abort, 14'h100 + 14'(i), i == 0, i == 9);
      end
    end
  endtask

  task automatic test_simultaneous;
    int expCh;
    logic [13:0] expD;
    // Fresh pointer: ch0 goes first.
    Reset = 1'b1; repeat (2) @(posedge ipDspClk); #1; Reset = 1'b0;
    got.delete(); ipReady = 1'b1;
    fork
      drive(2'b11, 4, 14'h200, 14'h300);
      waitWords(8, 100);
    join
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL pair1_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      expCh = (i < 4) ? 0 : 1;
      expD  = (expCh == 0 ? 14'h200 : 14'h300) + 14'(i % 4);
      checks++;
      if (got[i].ch !== expCh || got[i].data !== expD || got[i].sop !== (i % 4 == 0) || got[i].eop !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL pair1_word%0d got ch=%0d d=%h s=%b e=%b exp ch=%0d d=%h", i, got[i].ch, got[i].data,
                 got[i].sop, got[i].eop, expCh, expD);
      end
    end
    // Lone ch0 packet: ch0 becomes the last grant.
    got.delete();
    fork
      drive(2'b01, 3, 14'h210, 14'h0);
      waitWords(3, 60);
    join
    checks++; if (got.size() !== 3 || got[0].ch !== 0 || got[2].eop !== 1'b1) begin failures++;
      $display("FAIL lone_ch0 got n=%0d exp n=3 ch0", got.size()); end
    // Next pair: search starts after ch0, so ch1 first.
    got.delete();
    fork
      drive(2'b11, 4, 14'h220, 14'h320);
      waitWords(8, 100);
    join
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL pair2_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      expCh = (i < 4) ? 1 : 0;
      expD  = (expCh == 0 ? 14'h220 : 14'h320) + 14'(i % 4);
      checks++;
      if (got[i].ch !== expCh || got[i].data !== expD || got[i].sop !== (i % 4 == 0) || got[i].eop !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL pair2_word%0d got ch=%0d d=%h exp ch=%0d d=%h", i, got[i].ch, got[i].data, expCh, expD);
      end
    end
  endtask

  task automatic test_stall;
    int stalls = 0, bad = 0;
    logic held = 1'b0;
    tPacket hp; logic [1:0] hc; logic ha;
    hp = '0; hc = '0; ha = 1'b0;
    got.delete(); ipReady = 1'b0;
    fork
      drive(2'b01, 6, 14'h400, 14'h0);
      for (int k = 0; k < 80 && got.size() < 6; k++) begin
        @(posedge ipDspClk); #1; ipReady = ~ipReady;
        @(negedge ipDspClk);
        if (held) begin
          stalls++;
          if (opPacket !== hp || opChannel !== hc || opAbort !== ha) bad++;
        end
        held = opPacket.Valid && !ipReady;
        hp = opPacket; hc = opChannel; ha = opAbort;
      end
    join
    ipReady = 1'b1;
    waitWords(6, 20);
    checks++; if (bad !== 0 || stalls == 0) begin failures++; $display("FAIL stall_stable got unstable=%0d stalls=%0d exp unstable=0 stalls>0", bad, stalls); end
    checks++; if (got.size() !== 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i].data !== 14'h400 + 14'(i) || got[i].sop !== (i == 0) || got[i].eop !== (i == 5)) begin
        failures++;
        $display("FAIL stall_word%0d got d=%h s=%b e=%b exp d=%h", i, got[i].data, got[i].sop, got[i].eop, 14'h400 + 14'(i));
      end
    end
  endtask

  task automatic test_overflow;
    got.delete(); ipReady = 1'b0;
    drive(2'b01, 20, 14'h500, 14'h0);
    repeat (3) @(posedge ipDspClk);
    @(negedge ipDspClk);
    checks++; if (opOverflow !== 2'b01) begin failures++; $display("FAIL ovf_flag got=%b exp=01", opOverflow); end
    checks++; if (opPacket.Valid !== 1'b1 || opPacket.SoP !== 1'b1 || opPacket.Data !== 14'h500) begin failures++;
      $display("FAIL ovf_stalled_head got v=%b s=%b d=%h exp v=1 s=1 d=0500", opPacket.Valid, opPacket.SoP, opPacket.Data); end
    ipReady = 1'b1;
    waitWords(8, 60);
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 7; i++) begin
      checks++;
      if (got[i].ch !== 0 || got[i].data !== 14'h500 + 14'(i) || got[i].sop !== (i == 0) ||
          got[i].eop !== 1'b0 || got[i].abort !== 1'b0) begin
        failures++;
        $display("FAIL ovf_word%0d got d=%h s=%b e=%b a=%b exp d=%h e=0 a=0", i, got[i].data, got[i].sop,
                 got[i].eop, got[i].abort, 14'h500 + 14'(i));
      end
    end
    if (got.size() >= 8) begin
      checks++;
      if (got[7].sop !== 1'b0 || got[7].eop !== 1'b1 || got[7].abort !== 1'b1 || got[7].data !== 14'h0) begin
        failures++;
        $display("FAIL ovf_marker got s=%b e=%b a=%b d=%h exp s=0 e=1 a=1 d=0000", got[7].sop, got[7].eop, got[7].abort, got[7].data);
      end
    end
  endtask

  task automatic test_recover;
    got.delete(); ipReady = 1'b1;
    fork
      drive(2'b01, 5, 14'h600, 14'h0);
      waitWords(5, 60);
    join
    checks++; if (got.size() !== 5) begin failures++; $display("FAIL recover_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      checks++;
      if (got[i].ch !== 0 || got[i].data !== 14'h600 + 14'(i) || got[i].sop !== (i == 0) ||
          got[i].eop !== (i == 4) || got[i].abort !== 1'b0) begin
        failures++;
        $display("FAIL recover_word%0d got d=%h s=%b e=%b a=%b exp d=%h", i, got[i].data, got[i].sop,
                 got[i].eop, got[i].abort, 14'h600 + 14'(i));
      end
    end
    checks++; if (opOverflow !== 2'b01) begin failures++; $display("FAIL recover_ovf_sticky got=%b exp=01", opOverflow); end
  endtask

  task automatic test_reset_mid_packet;
    logic found = 1'b0;
    got.delete(); ipReady = 1'b1;
    fork
      drive(2'b01, 10, 14'h700, 14'h0);
      begin
        for (int k = 0; k < 40 && !found; k++) begin
          @(negedge ipDspClk);
          if (opPacket.Valid && opPacket.Data == 14'h704) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_word5 got=absent exp=present"); end
        #1; Reset = 1'b1; got.delete();
        @(posedge ipDspClk); @(negedge ipDspClk);
        checks++; if (opPacket.Valid !== 1'b0 || opChannel !== 2'd0 || opAbort !== 1'b0) begin failures++;
          $display("FAIL rstmid_outputs got v=%b ch=%0d a=%b exp v=0 ch=0 a=0", opPacket.Valid, opChannel, opAbort); end
        checks++; if (dut.fifoEmpty !== 2'b11) begin failures++; $display("FAIL rstmid_flush got=%b exp=11", dut.fifoEmpty); end
        repeat (3) @(posedge ipDspClk);
        #1; Reset = 1'b0;
      end
    join
    repeat (6) @(posedge ipDspClk);
    @(negedge ipDspClk);
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL rstmid_no_tail got=%0d exp=0", got.size()); end
    got.delete();
    fork
      drive(2'b11, 3, 14'h710, 14'h810);
      waitWords(6, 80);
    join
    checks++; if (got.size() !== 6) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i].ch !== (i < 3 ? 0 : 1) || got[i].data !== (i < 3 ? 14'h710 : 14'h810) + 14'(i % 3) ||
          got[i].sop !== (i % 3 == 0) || got[i].eop !== (i % 3 == 2)) begin
        failures++;
        $display("FAIL rstmid_after_word%0d got ch=%0d d=%h exp ch=%0d", i, got[i].ch, got[i].data, i < 3 ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_stall();
    test_overflow();
    test_recover();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
